// File: rtl/rc4_decrypt_pkg.sv
// rc4_decrypt_pkg: shared types and sizes for the RC4 decryption sequencer.
// Holds the FSM state enum, word/lane geometry and a last-byte helper.
package rc4_decrypt_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * LANE_W;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT,
        OUT
    } state_t;

    function automatic logic is_last_byte(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/rc4_decrypt_ctrl_lane_xor.sv
// ks_lane_xor: XORs one keystream byte into the byte lane chosen by idx.
// Ports: word_i (word), idx_i (lane), ks_byte_i (byte), word_o (result).
module ks_lane_xor
    import rc4_decrypt_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LANE_W-1:0] ks_byte_i,
    output logic [WORD_W-1:0] word_o
);

    always_comb begin
        word_o = word_i;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (idx_i == IDX_W'(b)) begin
                word_o[b*LANE_W +: LANE_W] =
                    word_i[b*LANE_W +: LANE_W] ^ ks_byte_i;
            end
        end
    end

endmodule

// File: rtl/rc4_decrypt_ctrl.sv
// rc4_decrypt_ctrl: takes ciphertext words, XORs in four keystream bytes
// (lane 0 first) and hands plaintext downstream; counts words per frame.
// Ports: clk_i, rst_i (async, active-high); key_ready_i, read_ready_i,
//   rc4_data_i, read_ack_o (ciphertext side); ks_req_o, ks_valid_i,
//   ks_byte_i (keystream side); plain_valid_o, plain_data_o,
//   plain_ready_i (plaintext side); busy_o, word_count_o, frame_done_o.
// Option: RC4_DECRYPT_BYPASS_EN adds bypass_i, which passes a word
//   through untouched (LOAD goes straight to OUT).
module rc4_decrypt_ctrl
    import rc4_decrypt_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 4096,
    parameter int COUNT_W         = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
`ifdef RC4_DECRYPT_BYPASS_EN
    input  logic               bypass_i,
`endif
    input  logic               key_ready_i,
    input  logic               read_ready_i,
    input  logic [31:0]        rc4_data_i,
    output logic               read_ack_o,
    output logic               ks_req_o,
    input  logic               ks_valid_i,
    input  logic [7:0]         ks_byte_i,
    output logic               plain_valid_o,
    output logic [31:0]        plain_data_o,
    input  logic               plain_ready_i,
    output logic               busy_o,
    output logic [COUNT_W-1:0] word_count_o,
    output logic               frame_done_o
);

    state_t              state_q;
    state_t              state_d;
    logic [WORD_W-1:0]   word_q;
    logic [WORD_W-1:0]   word_xor;
    logic [IDX_W-1:0]    idx_q;
    logic [COUNT_W-1:0]  count_q;
    logic [COUNT_W-1:0]  count_inc;
    logic                frame_done_q;
    logic                capture;
    logic                wrap;
    logic                bypass_q;

    assign capture   = key_ready_i && read_ready_i;
    assign count_inc = count_q + COUNT_W'(1);
    // Also covers WORDS_PER_FRAME == 2**COUNT_W, where both sides wrap to 0.
    assign wrap      = count_inc == COUNT_W'(WORDS_PER_FRAME);

    ks_lane_xor u_lane_xor (
        .word_i    (word_q),
        .idx_i     (idx_q),
        .ks_byte_i (ks_byte_i),
        .word_o    (word_xor)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = bypass_q ? OUT : REQ;
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ks_valid_i) begin
                    state_d = is_last_byte(idx_q) ? OUT : REQ;
                end
            end
            OUT: begin
                if (plain_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef RC4_DECRYPT_BYPASS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bypass_q <= 1'b0;
        end else if (state_q == IDLE && capture) begin
            bypass_q <= bypass_i;
        end
    end
`else
    assign bypass_q = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q       <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (capture) begin
                        word_q <= rc4_data_i;
                        idx_q  <= '0;
                    end
                end
                WAIT: begin
                    if (ks_valid_i) begin
                        word_q <= word_xor;
                        idx_q  <= idx_q + IDX_W'(1);
                    end
                end
                OUT: begin
                    if (plain_ready_i) begin
                        count_q      <= wrap ? '0 : count_inc;
                        frame_done_q <= wrap;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Every output is a state decode or a flop, so none follows an input.
    assign read_ack_o    = state_q == LOAD;
    assign ks_req_o      = state_q == REQ;
    assign plain_valid_o = state_q == OUT;
    assign busy_o        = state_q != IDLE;
    assign plain_data_o  = word_q;
    assign word_count_o  = count_q;
    assign frame_done_o  = frame_done_q;

endmodule
